// File: rtl/frame_sequencer.sv
// Frame select sequencer for the LED panel frame store.
// Advances frames only on full-panel refresh boundaries.
module frame_sequencer #(
  parameter int N_FRAMES = 15,
  parameter int HOLD_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold_count,
  input  logic              refresh_done,
  input  logic              step,
  input  logic              restart,
  output logic [7:0]        frame_num,
  output logic              frame_tick,
  output logic              done,
  output logic              active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(N_FRAMES - 1);

  state_t            state, state_n;
  logic [7:0]        frame_n;
  logic              dir, dir_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              restart_pend, rp_n;
  logic              step_pend, sp_n;
  logic              tick_n;

  logic [7:0]        adv_frame;
  logic              adv_dir;
  logic              adv_fin;
  logic              restart_eff;
  logic              step_eff;
  logic [HOLD_W:0]   cnt_inc;
  logic [HOLD_W:0]   target;
  logic              hit;

  // dir: 0 = counting up, 1 = counting down
  always_comb begin
    adv_frame = frame_num;
    adv_dir   = dir;
    adv_fin   = 1'b0;
    unique case (mode)
      2'b00: begin
        adv_frame = (frame_num == LAST) ? 8'd0 : frame_num + 8'd1;
        if (adv_frame == 8'd0)
          adv_dir = 1'b0;
      end
      2'b01: begin
        if (!dir) begin
          if (frame_num != LAST)
            adv_frame = frame_num + 8'd1;
          else if (LAST != 8'd0) begin
            adv_frame = frame_num - 8'd1;
            adv_dir   = 1'b1;
          end
        end else begin
          if (frame_num != 8'd0)
            adv_frame = frame_num - 8'd1;
          else if (LAST != 8'd0) begin
            adv_frame = 8'd1;
            adv_dir   = 1'b0;
          end
        end
      end
      2'b10: begin
        if (frame_num != LAST)
          adv_frame = frame_num + 8'd1;
        adv_fin = (adv_frame == LAST);
      end
      2'b11: begin
      end
    endcase
  end

  assign restart_eff = restart | restart_pend;
  assign step_eff    = step | step_pend;
  assign cnt_inc     = {1'b0, hold_cnt} + {{HOLD_W{1'b0}}, 1'b1};
  assign target      = (hold_count == '0) ? {{HOLD_W{1'b0}}, 1'b1}
                                          : {1'b0, hold_count};
  assign hit         = (cnt_inc >= target);

  always_comb begin
    state_n = state;
    frame_n = frame_num;
    dir_n   = dir;
    hold_n  = hold_cnt;
    rp_n    = restart_eff;
    sp_n    = step_eff;
    tick_n  = 1'b0;
    unique case (state)
      S_IDLE:  if (enable) state_n = S_RUN;
      S_RUN:   if (!enable) state_n = S_IDLE;
      default: state_n = state;
    endcase
    if (refresh_done) begin
      rp_n = 1'b0;
      sp_n = 1'b0;
      if (restart_eff) begin
        frame_n = 8'd0;
        dir_n   = 1'b0;
        hold_n  = '0;
        state_n = S_IDLE;
        tick_n  = 1'b1;
      end else if (mode == 2'b11) begin
        hold_n = '0;
        sp_n   = step_eff;
      end else if ((step_eff && state == S_IDLE) ||
                   (state == S_RUN && hit)) begin
        if (state == S_RUN)
          hold_n = '0;
        frame_n = adv_frame;
        dir_n   = adv_dir;
        tick_n  = 1'b1;
        if (adv_fin)
          state_n = S_DONE;
      end else if (state == S_RUN) begin
        hold_n = cnt_inc[HOLD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_num    <= 8'd0;
      dir          <= 1'b0;
      hold_cnt     <= '0;
      restart_pend <= 1'b0;
      step_pend    <= 1'b0;
      frame_tick   <= 1'b0;
      done         <= 1'b0;
      active       <= 1'b0;
    end else begin
      state        <= state_n;
      frame_num    <= frame_n;
      dir          <= dir_n;
      hold_cnt     <= hold_n;
      restart_pend <= rp_n;
      step_pend    <= sp_n;
      frame_tick   <= tick_n;
      done         <= (state_n == S_DONE);
      active       <= (state_n == S_RUN);
    end
  end

endmodule
